// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag indices and FSM encoding
// for the handshaked sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_DEC = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: one shift-add step per cycle, LSB of b first.
// product_o is the running sum including the current step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic               run_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;

    assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = run_q && (cnt_q == CW'(WIDTH - 1));

    // Load operands on start, then accumulate one partial product per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (run_q) begin
            acc_q    <= product_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and flags,
// iterative multiply, illegal-opcode error and idle sleep.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int SLEEP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic             busy,
    output logic             sleep
);

    localparam int M  = WIDTH - 1;
    localparam int SW = $clog2(SLEEP_CYCLES + 1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic               err_q;
    logic [SW-1:0]      idle_q, idle_d;

    logic               accept, is_mul, mul_done;
    logic [WIDTH-1:0]   opa, opb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_d, prod_lo;
    logic [WIDTH:0]     sum;
    logic               c_d, v_d, err_d;

    assign in_ready  = rst_n &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_OUT) && out_ready));
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q == ST_MUL);
    assign sleep     = (idle_q == SW'(SLEEP_CYCLES));
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign prod_lo   = prod[WIDTH-1:0];

    // Operands reach the datapath only for an accepted op.
    assign opa = accept ? a : '0;
    assign opb = accept ? b : '0;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul),
        .a_i       (opa),
        .b_i       (opb),
        .done_o    (mul_done),
        .product_o (prod)
    );

    // Single-cycle datapath with carry/borrow and overflow.
    always_comb begin
        res_d = '0;
        sum   = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        err_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum   = {1'b0, opa} + {1'b0, opb};
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (opa[M] == opb[M]) && (res_d[M] != opa[M]);
            end
            OP_SUB: begin
                sum   = {1'b0, opa} - {1'b0, opb};
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (opa[M] != opb[M]) && (res_d[M] != opa[M]);
            end
            OP_AND: res_d = opa & opb;
            OP_OR:  res_d = opa | opb;
            OP_XOR: res_d = opa ^ opb;
            OP_NOT: res_d = ~opa;
            OP_INC: begin
                sum   = {1'b0, opa} + ONE;
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = !opa[M] && res_d[M];
            end
            OP_DEC: begin
                sum   = {1'b0, opa} - ONE;
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = opa[M] && !res_d[M];
            end
            OP_SHL: begin
                res_d = {opa[M-1:0], 1'b0};
                c_d   = opa[M];
            end
            OP_SHR: begin
                res_d = {1'b0, opa[M:1]};
                c_d   = opa[0];
            end
            OP_ROL: begin
                res_d = {opa[M-1:0], opa[M]};
                c_d   = opa[M];
            end
            OP_ROR: begin
                res_d = {opa[0], opa[M:1]};
                c_d   = opa[0];
            end
            OP_MUL: res_d = '0;
            default: err_d = 1'b1;
        endcase
    end

    // Next state and saturating idle count.
    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_OUT;
            ST_MUL:  if (mul_done) state_d = ST_OUT;
            ST_OUT: begin
                if (accept)         state_d = is_mul ? ST_MUL : ST_OUT;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q == ST_IDLE) && !in_valid) begin
            idle_d = sleep ? idle_q : idle_q + SW'(1);
        end
    end

    // State and idle-count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    // Output register: loaded on a finished multiply or an accepted op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else if (mul_done) begin
            result_q         <= prod_lo;
            flags_q[FLAG_N]  <= prod_lo[M];
            flags_q[FLAG_Z]  <= (prod_lo == '0);
            flags_q[FLAG_C]  <= |prod[2*WIDTH-1:WIDTH];
            flags_q[FLAG_V]  <= 1'b0;
            err_q            <= 1'b0;
        end else if (accept && !is_mul) begin
            result_q         <= res_d;
            flags_q[FLAG_N]  <= res_d[M];
            flags_q[FLAG_Z]  <= (res_d == '0);
            flags_q[FLAG_C]  <= c_d;
            flags_q[FLAG_V]  <= v_d;
            err_q            <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results
// for alu_seq at WIDTH=16.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err, busy, sleep;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq #(.WIDTH(16), .SLEEP_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err),
        .busy      (busy),
        .sleep     (sleep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
    endtask

    task automatic run_mul(input string tag, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] er,
                           input logic [3:0] ef);
        int lat;
        int nbusy;
        int nrdy;
        drive(OP_MUL, x, y);
        step();
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        lat = 1;
        nbusy = 0;
        nrdy = 0;
        while (!out_valid && lat < 40) begin
            if (busy) nbusy++;
            if (in_ready) nrdy++;
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, 17);
        check({tag, "_busy"}, nbusy, 16);
        check({tag, "_rdy"}, nrdy, 0);
        check({tag, "_res"}, result, er);
        check({tag, "_flg"}, flags, ef);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        repeat (2) step();
        check("rst_rdy_low", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rst_rdy", in_ready, 1);
        check("rst_ov", out_valid, 0);
        check("rst_res", result, 0);
        check("rst_flg", flags, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_sleep", sleep, 0);

        drive(OP_ADD, 16'hFFFF, 16'h0001);
        step();
        check("add_ov", out_valid, 1);
        check("add_res", result, 16'h0000);
        check("add_flg", flags, 4'b0110);
        drive(OP_SUB, 16'h8000, 16'h0001);
        step();
        check("sub_res", result, 16'h7FFF);
        check("sub_flg", flags, 4'b0001);
        drive(OP_ROR, 16'h00B3, 16'h0000);
        step();
        check("ror_res", result, 16'h8059);
        check("ror_flg", flags, 4'b1010);
        in_valid = 1'b0;
        step();
        check("idle_ov", out_valid, 0);

        run_mul("mul1", 16'h0123, 16'h0010, 16'h1230, 4'b0000);
        run_mul("mul2", 16'hFFFF, 16'h0002, 16'hFFFE, 4'b1010);
        step();

        out_ready = 1'b0;
        drive(OP_ADD, 16'h0005, 16'h0003);
        step();
        check("bp_add_ov", out_valid, 1);
        check("bp_add_res", result, 16'h0008);
        drive(OP_XOR, 16'h00F0, 16'h0FF0);
        for (int i = 0; i < 3; i++) begin
            check("bp_rdy", in_ready, 0);
            check("bp_hold", result, 16'h0008);
            check("bp_ov", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", in_ready, 1);
        step();
        check("bp_xor_res", result, 16'h0F00);
        check("bp_xor_flg", flags, 4'b0000);
        drive(OP_NOT, 16'h00FF, 16'h0000);
        step();
        check("bp_not_res", result, 16'hFF00);
        check("bp_not_flg", flags, 4'b1000);

        drive(4'hE, 16'h0001, 16'h0001);
        step();
        check("ill_res", result, 16'h0000);
        check("ill_flg", flags, 4'b0100);
        check("ill_err", err, 1);
        drive(OP_AND, 16'hF0F0, 16'hFF00);
        step();
        check("and_res", result, 16'hF000);
        check("and_flg", flags, 4'b1000);
        check("and_err", err, 0);
        in_valid = 1'b0;

        step();
        repeat (7) step();
        check("sleep_7", sleep, 0);
        step();
        check("sleep_8", sleep, 1);
        repeat (3) step();
        check("sleep_sat", sleep, 1);
        drive(OP_ADD, 16'd120, 16'd10);
        #1;
        check("sleep_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("wake_sleep", sleep, 0);
        check("wake_ov", out_valid, 1);
        check("wake_res", result, 16'd130);

        step();
        drive(OP_MUL, 16'd3, 16'd5);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("mrst_busy", busy, 1);
        rst_n = 1'b0;
        step();
        check("mrst_ov", out_valid, 0);
        check("mrst_busy0", busy, 0);
        check("mrst_res", result, 0);
        check("mrst_flg", flags, 0);
        check("mrst_err", err, 0);
        check("mrst_sleep", sleep, 0);
        check("mrst_rdy", in_ready, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen++;
        end
        check("mrst_no_out", seen, 0);
        check("mrst_rdy1", in_ready, 1);
        check("mrst_res1", result, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
